// File: rtl/cpu_pkg.sv
// Shared constants, opcodes and state encoding for the RISC core control path.
package cpu_pkg;

   localparam int IW = 49;
   localparam int AW = 6;

   localparam logic [4:0] OP_LD  = 5'h08;
   localparam logic [4:0] OP_ST  = 5'h09;
   localparam logic [4:0] OP_BZ  = 5'h10;
   localparam logic [4:0] OP_BNZ = 5'h11;
   localparam logic [4:0] OP_BRA = 5'h12;
   localparam logic [4:0] OP_HLT = 5'h1F;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      HALT   = 3'd6
   } state_t;

   function automatic logic [4:0] opcode_of(input logic [IW-1:0] instr);
      return instr[IW-1:IW-5];
   endfunction

   // Branch decision uses the flag captured by the last EXEC, never the live ALU flag.
   function automatic logic branch_taken(input logic [4:0] op, input logic zflag);
      logic taken;
      case (op)
         OP_BZ:   taken = zflag;
         OP_BNZ:  taken = ~zflag;
         OP_BRA:  taken = 1'b1;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer-to-datapath bundle: ROM fetch, ALU flag, memory handshake and strobes.
interface cpu_sequencer_if;
   import cpu_pkg::*;

   logic          run;
   logic [IW-1:0] instr;
   logic          z_in;
   logic          mem_ack;
   logic [AW-1:0] pc;
   logic [IW-1:0] ir;
   logic          alu_en;
   logic          rf_we;
   logic          mem_req;
   logic          mem_we;
   logic          halted;
   logic [2:0]    state_dbg;

   modport master (
      input  run, instr, z_in, mem_ack,
      output pc, ir, alu_en, rf_we, mem_req, mem_we, halted, state_dbg
   );

   modport slave (
      output run, instr, z_in, mem_ack,
      input  pc, ir, alu_en, rf_we, mem_req, mem_we, halted, state_dbg
   );

endinterface

// File: rtl/cpu_sequencer_opclass.sv
// Combinational opcode classifier shared by the sequencer and the instruction decoder.
module seq_opclass
   import cpu_pkg::*;
(
   input  logic [4:0] opcode,
   output logic       is_branch,
   output logic       is_ld,
   output logic       is_st,
   output logic       is_hlt
);

   always_comb begin
      is_branch = 1'b0;
      is_ld     = 1'b0;
      is_st     = 1'b0;
      is_hlt    = 1'b0;
      case (opcode)
         OP_BZ, OP_BNZ, OP_BRA: is_branch = 1'b1;
         OP_LD:                 is_ld     = 1'b1;
         OP_ST:                 is_st     = 1'b1;
         OP_HLT:                is_hlt    = 1'b1;
         default:               is_branch = 1'b0;
      endcase
   end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: owns pc and ir, resolves branches,
// and issues one ALU / memory / writeback strobe per instruction.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int ROM_LAT = 1
) (
   input  logic            clk,
   input  logic            rst,
   cpu_sequencer_if.master bus
);

   localparam logic [1:0]    CNT_LAST = 2'(ROM_LAT - 1);
   localparam logic [AW-1:0] PC_ONE   = AW'(1);

   state_t        state_r;
   state_t        state_s;
   logic [AW-1:0] pc_r;
   logic [IW-1:0] ir_r;
   logic          zflag_r;
   logic          run_r;
   logic [1:0]    cnt_r;

   logic [4:0]    opcode_s;
   logic          is_branch_s;
   logic          is_ld_s;
   logic          is_st_s;
   logic          is_hlt_s;
   logic [AW-1:0] pc_inc_s;
   logic [AW-1:0] tgt_s;
   logic          last_fetch_s;
   logic          resume_s;

   assign opcode_s     = opcode_of(ir_r);
   assign pc_inc_s     = pc_r + PC_ONE;
   assign tgt_s        = ir_r[AW-1:0];
   assign last_fetch_s = (cnt_r == CNT_LAST);
   assign resume_s     = bus.run & ~run_r;

   seq_opclass u_opclass (
      .opcode    (opcode_s),
      .is_branch (is_branch_s),
      .is_ld     (is_ld_s),
      .is_st     (is_st_s),
      .is_hlt    (is_hlt_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Unreachable encodings fall back to IDLE through the default arm.
   always_comb begin
      state_s = IDLE;
      case (state_r)
         IDLE:    if (bus.run) state_s = FETCH; else state_s = IDLE;
         FETCH:   if (last_fetch_s) state_s = DECODE; else state_s = FETCH;
         DECODE:  if (is_branch_s) state_s = FETCH;
                  else if (is_hlt_s) state_s = HALT;
                  else state_s = EXEC;
         EXEC:    if (is_ld_s || is_st_s) state_s = MEM; else state_s = WB;
         MEM:     if (!bus.mem_ack) state_s = MEM;
                  else if (is_ld_s) state_s = WB;
                  else state_s = FETCH;
         WB:      state_s = FETCH;
         HALT:    if (resume_s) state_s = FETCH; else state_s = HALT;
         default: state_s = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r    <= '0;
         ir_r    <= '0;
         zflag_r <= 1'b0;
         run_r   <= 1'b0;
         cnt_r   <= 2'd0;
      end else begin
         run_r <= bus.run;
         case (state_r)
            FETCH: begin
               if (last_fetch_s) begin
                  ir_r  <= bus.instr;
                  cnt_r <= 2'd0;
               end else begin
                  cnt_r <= cnt_r + 2'd1;
               end
            end
            DECODE: if (is_branch_s) pc_r <= branch_taken(opcode_s, zflag_r) ? tgt_s : pc_inc_s;
            EXEC:   zflag_r <= bus.z_in;
            MEM:    if (bus.mem_ack && is_st_s) pc_r <= pc_inc_s;
            WB:     pc_r <= pc_inc_s;
            HALT:   if (resume_s) pc_r <= pc_inc_s;
            default: cnt_r <= 2'd0;
         endcase
      end
   end

   // Moore strobes decoded from the registered state only.
   always_comb begin
      bus.alu_en  = 1'b0;
      bus.rf_we   = 1'b0;
      bus.mem_req = 1'b0;
      bus.mem_we  = 1'b0;
      bus.halted  = 1'b0;
      case (state_r)
         EXEC:    bus.alu_en = 1'b1;
         MEM: begin
            bus.mem_req = 1'b1;
            bus.mem_we  = is_st_s;
         end
         WB:      bus.rf_we  = 1'b1;
         HALT:    bus.halted = 1'b1;
         default: bus.alu_en = 1'b0;
      endcase
   end

   assign bus.pc        = pc_r;
   assign bus.ir        = ir_r;
   assign bus.state_dbg = state_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized program run against an instruction-level trace model, plus a directed
// reset-during-MEM check.
module tb_cpu_sequencer;
   import cpu_pkg::*;

   localparam int RL   = 1;
   localparam int MAXC = 3000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cpu_sequencer_if bus ();

   cpu_sequencer #(.ROM_LAT(RL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [IW-1:0] rom [64];
   assign bus.instr = rom[bus.pc];

   // Expected per-cycle trace and the stimulus that goes with each cycle.
   state_t        tr_st  [MAXC];
   logic [AW-1:0] tr_pc  [MAXC];
   logic [IW-1:0] tr_ir  [MAXC];
   logic          tr_we  [MAXC];
   logic          tr_run [MAXC];
   logic          tr_z   [MAXC];
   logic          tr_ack [MAXC];
   int            ack_n  [64];
   int            n_tr;

   logic [AW-1:0] m_pc;
   logic [IW-1:0] m_ir;
   logic          m_z;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc   = -1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [IW-1:0] mk(input logic [4:0] op, input logic [AW-1:0] tgt);
      logic [63:0] rnd;
      rnd = {$urandom(), $urandom()};
      return {op, rnd[43:AW], tgt};
   endfunction

   function automatic logic [4:0] alu_op();
      logic [4:0] op;
      op = 5'($urandom_range(0, 31));
      while (op == OP_LD || op == OP_ST || op == OP_BZ || op == OP_BNZ ||
             op == OP_BRA || op == OP_HLT)
         op = 5'($urandom_range(0, 31));
      return op;
   endfunction

   task automatic gen_rom();
      for (int a = 0; a < 64; a++) begin
         int r;
         logic [AW-1:0] t;
         r = $urandom_range(0, 99);
         t = AW'($urandom_range(0, 63));
         if (r < 40)      rom[a] = mk(alu_op(), t);
         else if (r < 55) rom[a] = mk(OP_LD, t);
         else if (r < 70) rom[a] = mk(OP_ST, t);
         else if (r < 78) rom[a] = mk(OP_BZ, t);
         else if (r < 86) rom[a] = mk(OP_BNZ, t);
         else if (r < 94) rom[a] = mk(OP_BRA, t);
         else             rom[a] = mk(OP_HLT, t);
         ack_n[a] = 0;
      end
      rom[0]     = mk(alu_op(), 6'h11);
      rom[1]     = mk(OP_BRA, 6'h05);
      rom[5]     = mk(OP_LD, 6'h22);
      rom[6]     = mk(OP_ST, 6'h33);
      rom[7]     = mk(OP_BZ, 6'h2A);
      rom[8]     = mk(alu_op(), 6'h01);
      rom[9]     = mk(OP_HLT, 6'h00);
      rom[6'h2A] = mk(OP_BRA, 6'h3F);
      rom[6'h3F] = mk(alu_op(), 6'h00);
      ack_n[5]   = 3;
      ack_n[6]   = 1;
   endtask

   task automatic push(input state_t st, input logic run, input logic z,
                       input logic ack, input logic we);
      tr_st[n_tr]  = st;
      tr_pc[n_tr]  = m_pc;
      tr_ir[n_tr]  = m_ir;
      tr_we[n_tr]  = we;
      tr_run[n_tr] = run;
      tr_z[n_tr]   = z;
      tr_ack[n_tr] = ack;
      n_tr++;
   endtask

   // Executes the program one instruction at a time, emitting the cycles each one costs.
   task automatic build_trace();
      logic [IW-1:0] w;
      logic [4:0]    op;
      logic [AW-1:0] tgt;
      logic          zv;
      int            n, h1, h2;
      m_pc = '0;
      m_ir = '0;
      m_z  = 1'b0;
      n_tr = 0;
      push(IDLE, 1'b0, rb(), rb(), 1'b0);
      push(IDLE, 1'b0, rb(), rb(), 1'b0);
      push(IDLE, 1'b1, rb(), rb(), 1'b0);
      while (n_tr < MAXC - 40) begin
         w   = rom[m_pc];
         op  = w[IW-1:IW-5];
         tgt = w[AW-1:0];
         repeat (RL) push(FETCH, 1'b1, rb(), rb(), 1'b0);
         m_ir = w;
         push(DECODE, 1'b1, rb(), rb(), 1'b0);
         if (op == OP_BZ) begin
            m_pc = m_z ? tgt : m_pc + 6'd1;
         end else if (op == OP_BNZ) begin
            m_pc = m_z ? m_pc + 6'd1 : tgt;
         end else if (op == OP_BRA) begin
            m_pc = tgt;
         end else if (op == OP_HLT) begin
            h1 = $urandom_range(1, 3);
            h2 = $urandom_range(1, 3);
            repeat (h1) push(HALT, 1'b1, rb(), rb(), 1'b0);
            repeat (h2) push(HALT, 1'b0, rb(), rb(), 1'b0);
            push(HALT, 1'b1, rb(), rb(), 1'b0);
            m_pc = m_pc + 6'd1;
         end else begin
            zv = rb();
            push(EXEC, 1'b1, zv, rb(), 1'b0);
            m_z = zv;
            if (op == OP_LD || op == OP_ST) begin
               n = (ack_n[m_pc] > 0) ? ack_n[m_pc] : $urandom_range(1, 4);
               for (int k = 0; k < n; k++)
                  push(MEM, 1'b1, rb(), (k == n - 1), (op == OP_ST));
               if (op == OP_LD) push(WB, 1'b1, rb(), rb(), 1'b0);
            end else begin
               push(WB, 1'b1, rb(), rb(), 1'b0);
            end
            m_pc = m_pc + 6'd1;
         end
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_state"}, bus.state_dbg, IDLE);
      chk({tag, "_pc"}, bus.pc, '0);
      chk({tag, "_ir"}, bus.ir, '0);
      chk({tag, "_strobes"}, {bus.alu_en, bus.rf_we, bus.mem_req, bus.mem_we, bus.halted}, 5'b0);
   endtask

   initial begin
      logic found;
      gen_rom();
      build_trace();
      rst         = 1'b1;
      bus.run     = 1'b0;
      bus.z_in    = 1'b0;
      bus.mem_ack = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset("reset");
      rst = 1'b0;

      for (int c = 0; c < n_tr; c++) begin
         cyc = c;
         chk("state", bus.state_dbg, tr_st[c]);
         chk("pc", bus.pc, tr_pc[c]);
         chk("ir", bus.ir, tr_ir[c]);
         chk("alu_en", bus.alu_en, (tr_st[c] == EXEC));
         chk("rf_we", bus.rf_we, (tr_st[c] == WB));
         chk("mem_req", bus.mem_req, (tr_st[c] == MEM));
         chk("mem_we", bus.mem_we, tr_we[c]);
         chk("halted", bus.halted, (tr_st[c] == HALT));
         bus.run     = tr_run[c];
         bus.z_in    = tr_z[c];
         bus.mem_ack = tr_ack[c];
         @(posedge clk);
         @(negedge clk);
      end

      // Reset while a load waits for its acknowledge.
      cyc = -2;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_reset("rst2");
      rst         = 1'b0;
      bus.run     = 1'b1;
      bus.mem_ack = 1'b0;
      found       = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.state_dbg == MEM) found = 1'b1;
      end
      chk("reach_mem", found, 1'b1);
      chk("ld_pc", bus.pc, 6'd5);
      chk("ld_we", bus.mem_we, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("ld_wait_req", bus.mem_req, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_reset("rst_mem");
      rst         = 1'b0;
      bus.run     = 1'b0;
      bus.mem_ack = 1'b1;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         chk("late_ack_state", bus.state_dbg, IDLE);
         chk("late_ack_req", bus.mem_req, 1'b0);
         chk("late_ack_pc", bus.pc, 6'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
